// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP encoding, opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection (jalr > jal/branch > sequential) plus target alignment check.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is consumed.
//
// Ports:
//   pc, imm32, rs1_data     : current PC, sign-extended immediate, jalr base
//   jal, jalr, branch_taken : redirect qualifiers for the current instruction
//   next_pc                 : selected next fetch address
//   misaligned              : next_pc[1:0] != 0 (only when INSTR_FETCH_MISALIGN_CHECK_EN)
// Macro INSTR_FETCH_MISALIGN_CHECK_EN: report misalignment instead of
// silently forcing the target onto a word boundary.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm32,
  input  logic [31:0] rs1_data,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] target;

  // All sums wrap modulo 2^32; no overflow indication.
  always_comb begin
    target = pc + 32'd4;
    if (jalr) begin
      target = (rs1_data + imm32) & ~32'h0000_0001;
    end else if (jal || branch_taken) begin
      target = pc + imm32;
    end
  end

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  assign next_pc    = target;
  assign misaligned = |target[1:0];
`else
  assign next_pc    = target & ~32'h0000_0003;
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: request word, wait for memory, present instr until accepted.
// Latency: req -> ready -> valid, min 3 cycles per instruction; timeout reissues the request.
// Backpressure: stall holds instr/pc_out/pc_plus4 in S_VALID; redirects sampled only on accept.
//
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   imem_req/imem_addr           : one-cycle read strobe and word address
//   imem_ready/imem_rdata        : memory response (honoured only in S_WAIT)
//   instr/instr_valid/pc_out     : fetched instruction and its address
//   pc_plus4                     : link value for jal/jalr
//   stall                        : downstream hold; accept = instr_valid & ~stall
//   branch_taken/jal/jalr/imm32/rs1_data : redirect information for instr
//   misalign_err                 : sticky misaligned-target flag
// Macro INSTR_FETCH_MISALIGN_CHECK_EN: enables misalign_err and the S_HALT trap.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm32,
  input  logic [31:0] rs1_data,
  output logic        misalign_err
);

  localparam int CNT_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [31:0]      pc;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             req_c;
  logic [31:0]      next_pc;
  logic             misaligned;

  pc_next_calc u_pc_next_calc (
    .pc           (pc),
    .imm32        (imm32),
    .rs1_data     (rs1_data),
    .jal          (jal),
    .jalr         (jalr),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_nxt   = state;
    req_c       = 1'b0;
    instr_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      S_REQ: begin
        req_c     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ready) begin
          state_nxt = S_VALID;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = S_REQ;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (!stall) begin
          accept    = 1'b1;
          // misaligned is constant 0 unless the check is compiled in,
          // which leaves S_HALT unreachable in the default build.
          state_nxt = misaligned ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Gate with rst_n so the strobe stays low while reset is held even though
  // the state register already sits in S_REQ.
  assign imem_req  = req_c & rst_n;
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // S_REQ is the only way into S_WAIT, so clearing here restarts the
      // timeout on every fresh wait.
      if (state == S_REQ) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == S_WAIT && imem_ready) begin
        instr <= imem_rdata;
      end
      if (accept && !misaligned) begin
        pc <= next_pc;
      end
    end
  end

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (accept && misaligned) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, redirects, stall hold,
// reset during wait with a stray ready, timeout reissue, misaligned target.
// Memory model answers one cycle after each request with data = addr ^ 32'h5A00_0000.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic [31:0] imm32;
  logic [31:0] rs1_data;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  logic        mem_en;
  logic        force_rdy;
  logic        pend;
  logic [31:0] pend_addr;
  logic        proto_bad;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .imm32        (imm32),
    .rs1_data     (rs1_data),
    .misalign_err (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder and req/valid exclusivity monitor, active on the falling edge.
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    pend       = 1'b0;
    pend_addr  = 32'h0;
    proto_bad  = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req && instr_valid) proto_bad = 1'b1;
      imem_ready = force_rdy;
      imem_rdata = force_rdy ? 32'hDEAD_BEEF : 32'h0;
      if (pend) begin
        pend       = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = pend_addr ^ 32'h5A00_0000;
      end
      if (imem_req && mem_en) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
      end
    end
  end

  // Advance falling edges until imem_req; returns address and edges consumed.
  task automatic wait_req(input string name, output logic [31:0] addr, output int n);
    addr = 32'hX;
    n    = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (imem_req) begin
        addr = imem_addr;
        n    = i;
        break;
      end
    end
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL %s: no imem_req within 40 cycles (got none, required one)", name);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no instr_valid within 40 cycles (got none, required one)", name);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++;
    if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    checks++;
    if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_out); end
    checks++;
    if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Cycle 0 is the first cycle after release: req every 3rd cycle, valid two later.
  task automatic test_sequential();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a;
      a = 32'(k / 3) * 32'd4;
      @(negedge clk);
      checks++;
      if ({imem_req, instr_valid} !== {1'(k % 3 == 0), 1'(k % 3 == 2)}) begin
        errors++;
        $display("FAIL seq_cycle%0d: req/valid got %b%b want %b%b", k, imem_req, instr_valid,
                 1'(k % 3 == 0), 1'(k % 3 == 2));
      end
      if (k % 3 == 0) begin
        checks++;
        if (imem_addr !== a) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, a); end
      end
      if (k % 3 == 2) begin
        checks++;
        if ({pc_out, instr} !== {a, a ^ 32'h5A00_0000}) begin
          errors++;
          $display("FAIL seq_instr%0d: pc/instr got %h/%h want %h/%h", k, pc_out, instr, a, a ^ 32'h5A00_0000);
        end
      end
    end
    @(posedge clk); #1;
    stall = 1'b1;
  endtask

  task automatic test_branch();
    logic [31:0] a;
    int n;
    wait_valid("branch_valid");
    checks++;
    if ({pc_out, instr} !== {32'h0000_0010, 32'h5A00_0010}) begin
      errors++; $display("FAIL branch_pre: pc/instr got %h/%h want 00000010/5a000010", pc_out, instr);
    end
    branch_taken = 1'b1; imm32 = 32'hFFFF_FFF8; stall = 1'b0;
    @(posedge clk); #1;
    branch_taken = 1'b0; imm32 = 32'h0; stall = 1'b1;
    wait_req("branch_req", a, n);
    checks++;
    if (a !== 32'h0000_0008) begin errors++; $display("FAIL branch_addr: got %h want 00000008", a); end
  endtask

  task automatic test_jalr();
    logic [31:0] a;
    int n;
    wait_valid("jalr_valid");
    jalr = 1'b1; rs1_data = 32'h0000_0101; imm32 = 32'h0000_0004; stall = 1'b0;
    checks++;
    if ({pc_out, pc_plus4} !== {32'h0000_0008, 32'h0000_000C}) begin
      errors++; $display("FAIL jalr_link: pc/pc_plus4 got %h/%h want 00000008/0000000c", pc_out, pc_plus4);
    end
    @(posedge clk); #1;
    jalr = 1'b0; rs1_data = 32'h0; imm32 = 32'h0; stall = 1'b1;
    wait_req("jalr_req", a, n);
    checks++;
    if (a !== 32'h0000_0104) begin errors++; $display("FAIL jalr_addr: got %h want 00000104", a); end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    int n;
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      branch_taken = ~branch_taken;
      imm32 = 32'h0000_0040;
      @(negedge clk);
      checks++;
      if ({imem_req, instr_valid, pc_out, instr} !== {1'b0, 1'b1, 32'h0000_0104, 32'h5A00_0104}) begin
        errors++;
        $display("FAIL stall_hold%0d: req/valid/pc/instr got %b/%b/%h/%h want 0/1/00000104/5a000104",
                 i, imem_req, instr_valid, pc_out, instr);
      end
    end
    @(posedge clk); #1;
    branch_taken = 1'b0; imm32 = 32'h0; stall = 1'b0;
    mem_en = 1'b0;  // leave the next request unanswered
    @(posedge clk); #1;
    stall = 1'b1;
    wait_req("stall_req", a, n);
    checks++;
    if (a !== 32'h0000_0108) begin errors++; $display("FAIL stall_next_addr: got %h want 00000108", a); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] a;
    int n;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, instr, pc_out, misalign_err} !== {1'b0, 1'b0, NOP, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rst_wait_state: req/valid/instr/pc/err got %b/%b/%h/%h/%b want 0/0/%h/0/0",
               imem_req, instr_valid, instr, pc_out, misalign_err, NOP);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rst_wait_req: req/addr got %b/%h want 1/00000000", imem_req, imem_addr);
    end
    @(posedge clk); #1;
    force_rdy = 1'b0;
    mem_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({instr_valid, instr} !== {1'b0, NOP}) begin
      errors++; $display("FAIL rst_stray_ready: valid/instr got %b/%h want 0/%h", instr_valid, instr, NOP);
    end
    // Unanswered request at cycle 0 is reissued at cycle 16 (15 wait cycles).
    wait_req("timeout_req", a, n);
    checks++;
    if ({32'(n + 2), a} !== {32'd16, 32'h0}) begin
      errors++; $display("FAIL timeout_reissue: cycle/addr got %0d/%h want 16/00000000", n + 2, a);
    end
    wait_valid("timeout_valid");
    checks++;
    if (instr !== 32'h5A00_0000) begin errors++; $display("FAIL timeout_instr: got %h want 5a000000", instr); end
  endtask

  task automatic test_misalign();
    logic [31:0] a;
    int n;
    wait_valid("mis_valid");
    jal = 1'b1; imm32 = 32'h0000_0006; stall = 1'b0;
    @(posedge clk); #1;
    jal = 1'b0; imm32 = 32'h0;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({misalign_err, imem_req, instr_valid} !== 3'b100) begin
        errors++;
        $display("FAIL mis_halt%0d: err/req/valid got %b/%b/%b want 1/0/0", i, misalign_err, imem_req, instr_valid);
      end
    end
`else
    wait_req("mis_req", a, n);
    checks++;
    if ({a, misalign_err} !== {32'h0000_0004, 1'b0}) begin
      errors++; $display("FAIL mis_addr: addr/err got %h/%b want 00000004/0", a, misalign_err);
    end
`endif
    stall = 1'b1;
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_bad !== 1'b0) begin
      errors++; $display("FAIL req_valid_overlap: got %b want 0", proto_bad);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm32 = 32'h0; rs1_data = 32'h0; mem_en = 1'b1; force_rdy = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall();
    test_reset_in_wait();
    test_misalign();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 Parameter IMEM_TIMEOUT, default 15, the maximum wait cycles for imem_ready before the request is reissued.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  one-cycle read request strobe to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_ready  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  current instruction to the decoder and immediate builder.
REQ-010 instr_valid  output  1  instr and pc_out are valid.
REQ-011 pc_out  output  32  address of instr.
REQ-012 pc_plus4  output  32  pc_out+4, the jal/jalr link value.
REQ-013 stall  input  1  downstream not accepting; accept = instr_valid & ~stall.
REQ-014 branch_taken  input  1  conditional branch resolved taken for instr.
REQ-015 jal  input  1  instr is jal.
REQ-016 jalr  input  1  instr is jalr.
REQ-017 imm32  input  32  sign-extended immediate of instr.
REQ-018 rs1_data  input  32  rs1 operand, used by jalr.
REQ-019 misalign_err  output  1  sticky misaligned-target flag.

Function
REQ-020 The FSM SHALL have the states S_REQ, S_WAIT, S_VALID, and S_HALT; the reset state is S_REQ.
REQ-021 In S_REQ: imem_req=1 and imem_addr=pc for exactly one cycle, then S_WAIT.
REQ-022 In S_WAIT: on imem_ready, capture imem_rdata into instr and go to S_VALID; imem_ready outside S_WAIT SHALL be ignored.
REQ-023 In S_WAIT, after IMEM_TIMEOUT cycles without imem_ready, return to S_REQ with the same pc; the wait counter clears on every entry to S_WAIT.
REQ-024 In S_VALID: instr_valid=1; instr, pc_out, and pc_plus4 are held stable while stall=1.
REQ-025 On accept, load pc with next_pc and go to S_REQ.
REQ-026 next_pc priority: jalr → (rs1_data+imm32)&~1; else jal or branch_taken → pc+imm32; else pc+4.
REQ-027 Redirect inputs SHALL be sampled only on the accept cycle and ignored otherwise.
REQ-028 All address arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
REQ-029 Minimum latency: S_REQ at cycle 0, imem_ready at cycle 1, instr_valid at cycle 2; maximum throughput is one instruction per 3 cycles.
REQ-030 imem_req and instr_valid SHALL never be high in the same cycle.

Reset
REQ-031 Asserting rst_n=0 at any time, including in S_WAIT, SHALL immediately force: pc=RESET_PC, state=S_REQ, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0, misalign_err=0, wait counter=0.
REQ-032 A late imem_ready for a request killed by reset SHALL be ignored, because the first post-reset cycle is S_REQ.
REQ-033 imem_req SHALL first assert in the first rising edge after rst_n deasserts.

Configuration
REQ-034 The feature SHALL be controlled by the macro INSTR_FETCH_MISALIGN_CHECK_EN.
REQ-035 With INSTR_FETCH_MISALIGN_CHECK_EN defined: if next_pc[1:0]!=0 on accept, set misalign_err=1, hold pc, and enter S_HALT; S_HALT is left only by reset.
REQ-036 With INSTR_FETCH_MISALIGN_CHECK_EN undefined: next_pc[1:0] is forced to 2'b00, S_HALT is unreachable, and misalign_err is tied to 0.

Structure
REQ-037 The shared package cpu_pkg SHALL hold the FSM state encoding, the NOP_INSTR constant 32'h0000_0013, and the opcode constants (OP_JAL 7'b1101111, OP_JALR 7'b1100111, OP_BRANCH 7'b1100011).
REQ-038 One sub-module, pc_next_calc, SHALL be purely combinational (next_pc and alignment check); the FSM and registers stay in instr_fetch.

Verification
REQ-039 Reset release with a 1-cycle-latency memory and stall=0: expect imem_addr 0x0, 0x4, 0x8 on successive requests and instr_valid every 3rd cycle.
REQ-040 Accept with branch_taken=1, pc=0x10, imm32=0xFFFF_FFF8: expect next imem_addr=0x08.
REQ-041 Accept with jalr=1, rs1_data=0x101, imm32=0x4: expect imem_addr=0x104 and pc_plus4=pc_out+4 at accept.
REQ-042 stall=1 for 5 cycles in S_VALID: expect instr and pc_out unchanged, no imem_req, and branch_taken pulses during stall ignored.
REQ-043 rst_n asserted in S_WAIT, then imem_ready arrives 1 cycle after release: expect the ready ignored and a fetch of RESET_PC.
REQ-044 With INSTR_FETCH_MISALIGN_CHECK_EN, accept jal with pc=0x0, imm32=0x6: expect misalign_err=1, S_HALT, and no further imem_req; without the macro, expect imem_addr=0x4.
